// File: rtl/run_sequencer.sv
// -----------------------------------------------------------------------------
// run_sequencer
//
// Generates the 3-bit instruction phase (0..7) for the VeriRISC control
// decoder. It is also the single run-control point for the CPU, with three
// modes: free-run, halted and single-step. A retired-instruction counter is
// exposed for debug use.
//
// Parameters
//   CNT_W          width of the retired-instruction counter
//   START_RUNNING  1 = leave reset in RUN, 0 = leave reset in HALTED
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   halt         halt request from the controller; honoured only in phase 4
//   go           resume pulse; honoured only while halted
//   step         single-instruction pulse; honoured only while halted
//   brk          (RUN_SEQUENCER_BREAK_EN only) breakpoint; honoured in RUN at
//                phase 7
//   phase        current instruction phase, registered
//   running      1 in RUN or STEP, 0 in HALTED
//   cycle_done   high during the phase-7 cycle of a completing instruction
//   instr_count  number of retired instructions, wraps modulo 2^CNT_W
//
// Optional feature macro: RUN_SEQUENCER_BREAK_EN (adds the brk input).
// -----------------------------------------------------------------------------
module run_sequencer #(
    parameter int CNT_W         = 16,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             go,
    input  logic             step,
`ifdef RUN_SEQUENCER_BREAK_EN
    input  logic             brk,
`endif
    output logic [2:0]       phase,
    output logic             running,
    output logic             cycle_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STEP   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [1:0] ST_RESET = START_RUNNING ? ST_RUN : ST_HALTED;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] phase_nxt;
    logic       retire;
    logic       active;
    logic       brk_hit;

    // A breakpoint only matters in free-run; a single step halts on its own.
`ifdef RUN_SEQUENCER_BREAK_EN
    assign brk_hit = brk && (state == ST_RUN);
`else
    assign brk_hit = 1'b0;
`endif

    assign active     = (state == ST_RUN) || (state == ST_STEP);
    assign running    = active;
    assign cycle_done = active && (phase == 3'd7);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        phase_nxt = phase;
        retire    = 1'b0;

        case (state)
            ST_HALTED: begin
                // Phase parks at 0; the first active cycle after leaving
                // HALTED therefore shows phase 0 for one cycle.
                phase_nxt = 3'd0;
                if (go) begin
                    state_nxt = ST_RUN;
                end else if (step) begin
                    state_nxt = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                if ((phase == 3'd4) && halt) begin
                    // HLT is abandoned after phase 4 but still counts as
                    // retired; the PC was already advanced in phase 4.
                    state_nxt = ST_HALTED;
                    phase_nxt = 3'd0;
                    retire    = 1'b1;
                end else if (phase == 3'd7) begin
                    phase_nxt = 3'd0;
                    retire    = 1'b1;
                    if ((state == ST_STEP) || brk_hit) begin
                        state_nxt = ST_HALTED;
                    end
                end else begin
                    phase_nxt = phase + 3'd1;
                end
            end

            default: begin
                // Unreachable encoding: park safely.
                state_nxt = ST_HALTED;
                phase_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state       <= ST_RESET;
            phase       <= 3'd0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule
